// File: rtl/video_tpg_multi.sv
// Multi-lane video test-pattern generator: sync/DE timing, five patterns and a frame counter.
// Optional TPG_SCROLL_EN: horizontal patterns (modes 0-2) scroll by one pixel per frame.
module video_tpg_multi #(
    parameter int DATA_W         = 10,
    parameter int PPC            = 1,
    parameter int H_ACTIVE       = 1280,
    parameter int H_FP           = 48,
    parameter int H_SYNC         = 32,
    parameter int H_BP           = 110,
    parameter int V_ACTIVE       = 728,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 44,
    parameter int V_BP           = 20,
    parameter int BAR_W          = 128,
    parameter int SYNC_POL       = 1,
    parameter int STARTUP_CYCLES = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [2:0]            mode,
    input  logic [DATA_W-1:0]     solid_val,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  fs,
    output logic [PPC*DATA_W-1:0] data,
    output logic [15:0]           frame_cnt
);

    // state   | meaning
    // ST_WAIT | post-reset settling, STARTUP_CYCLES clocks
    // ST_IDLE | counters parked at 0, waiting for enable
    // ST_RUN  | scanning frames; stop/relatch only at frame wrap
    typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_RUN} state_t;

    localparam int unsigned HT_C    = (H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC;
    localparam int unsigned VT_C    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_ACT_C = H_ACTIVE / PPC;
    localparam int unsigned H_HS_S  = (H_ACTIVE + H_FP) / PPC;
    localparam int unsigned H_HS_E  = (H_ACTIVE + H_FP + H_SYNC) / PPC;
    localparam int unsigned V_VS_S  = V_ACTIVE + V_FP;
    localparam int unsigned V_VS_E  = V_ACTIVE + V_FP + V_SYNC;
    localparam int HCW = (HT_C > 1) ? $clog2(HT_C) : 1;
    localparam int VCW = (VT_C > 1) ? $clog2(VT_C) : 1;
    localparam int WW  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam int LB  = $clog2(BAR_W);
    localparam int XW  = (DATA_W > LB + 3) ? DATA_W : LB + 3;
    localparam int YW  = (DATA_W > LB + 1) ? DATA_W : LB + 1;

    localparam logic [HCW-1:0] H_LAST   = HCW'(HT_C - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(VT_C - 1);
    localparam logic [WW-1:0]  WAIT_INI = WW'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic           SYNC_ACT = (SYNC_POL != 0);

    localparam int unsigned MAX_I = (1 << DATA_W) - 1;
    localparam logic [DATA_W-1:0] MAX_V = '1;
    // Colorbar levels floor(MAX*(7-b)/7), bar 0 brightest.
    localparam logic [DATA_W-1:0] CB_TBL [8] = '{
        DATA_W'(MAX_I),           DATA_W'((MAX_I * 6) / 7),
        DATA_W'((MAX_I * 5) / 7), DATA_W'((MAX_I * 4) / 7),
        DATA_W'((MAX_I * 3) / 7), DATA_W'((MAX_I * 2) / 7),
        DATA_W'(MAX_I / 7),       DATA_W'(0)
    };

    state_t                 state_q;
    logic [WW-1:0]          wait_q;
    logic [HCW-1:0]         hcnt_q;
    logic [VCW-1:0]         vcnt_q;
    logic [2:0]             mode_q;
    logic [DATA_W-1:0]      solid_q;
    logic [15:0]            frame_q;
    logic                   de_q, hs_q, vs_q, fs_q;
    logic [PPC*DATA_W-1:0]  data_q;

    logic                   run, h_last, v_last;
    logic                   de_d, hs_d, vs_d, fs_d;
    logic [PPC*DATA_W-1:0]  pix_d;
    logic [XW-1:0]          x_v, xs_v;
    logic [YW-1:0]          y_v;
    logic [DATA_W-1:0]      val_v;

    always_comb begin
        run    = (state_q == ST_RUN);
        h_last = (hcnt_q == H_LAST);
        v_last = (vcnt_q == V_LAST);
        de_d   = run && (32'(hcnt_q) < H_ACT_C) && (32'(vcnt_q) < V_ACTIVE);
        hs_d   = (run && (32'(hcnt_q) >= H_HS_S) && (32'(hcnt_q) < H_HS_E)) ? SYNC_ACT : ~SYNC_ACT;
        vs_d   = (run && (32'(vcnt_q) >= V_VS_S) && (32'(vcnt_q) < V_VS_E)) ? SYNC_ACT : ~SYNC_ACT;
        fs_d   = run && (hcnt_q == '0) && (vcnt_q == '0);
        pix_d  = '0;
        x_v    = '0;
        xs_v   = '0;
        val_v  = '0;
        y_v    = YW'(vcnt_q);
        for (int l = 0; l < PPC; l++) begin
            x_v = XW'(32'(hcnt_q) * PPC + l);
`ifdef TPG_SCROLL_EN
            xs_v = x_v + XW'(frame_q);
`else
            xs_v = x_v;
`endif
            case (mode_q)
                3'd0:    val_v = xs_v[DATA_W-1:0];
                3'd1:    val_v = CB_TBL[xs_v[LB+2:LB]];
                3'd2:    val_v = (xs_v[LB] ^ y_v[LB]) ? MAX_V : '0;
                3'd3:    val_v = solid_q;
                3'd4:    val_v = y_v[DATA_W-1:0];
                default: val_v = '0;
            endcase
            pix_d[l*DATA_W +: DATA_W] = val_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_WAIT;
            wait_q  <= WAIT_INI;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            frame_q <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_ACT;
            vs_q    <= ~SYNC_ACT;
            fs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (wait_q == '0) state_q <= ST_IDLE;
                    else              wait_q  <= wait_q - WW'(1);
                end
                ST_IDLE: begin
                    hcnt_q <= '0;
                    vcnt_q <= '0;
                    if (enable) begin
                        mode_q  <= mode;
                        solid_q <= solid_val;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (h_last) begin
                        hcnt_q <= '0;
                        if (v_last) begin
                            vcnt_q  <= '0;
                            frame_q <= frame_q + 16'd1;
                            if (enable) begin
                                mode_q  <= mode;
                                solid_q <= solid_val;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            vcnt_q <= vcnt_q + VCW'(1);
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HCW'(1);
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            data_q <= de_d ? pix_d : '0;
        end
    end

    assign de        = de_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign fs        = fs_q;
    assign data      = data_q;
    assign frame_cnt = frame_q;

endmodule
